// File: rtl/gb_clk_rst_gen.sv
// gb_clk_rst_gen: PLL lock qualification, sync reset and GB clock enables; GB_DOUBLE_SPEED_EN adds double_speed
module gb_clk_rst_gen #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       locked,
`ifdef GB_DOUBLE_SPEED_EN
    input  logic       double_speed,
`endif
    output logic       sys_reset,
    output logic       ce_ppu,
    output logic       ce_cpu,
    output logic       ce_m,
    output logic [7:0] lock_drops
);
    localparam int MAXC = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD_CYCLES - 1);
    typedef enum logic [1:0] {WAIT_LOCK, STABLE, HOLD, RUN} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] div_q, div_d;
    logic [7:0] lock_drops_q, lock_drops_d;
    logic meta_q, lock_s_q;
    logic speed_q, speed_d;
    logic sys_reset_q, sys_reset_d;
    logic ce_ppu_q, ce_ppu_d, ce_cpu_q, ce_cpu_d, ce_m_q, ce_m_d;
    logic run_d;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                state_d = lock_s_q ? STABLE : WAIT_LOCK;
                cnt_d = '0;
            end
            STABLE: begin
                state_d = !lock_s_q ? WAIT_LOCK : (cnt_q == STABLE_LAST) ? HOLD : STABLE;
                cnt_d = (cnt_q == STABLE_LAST) ? '0 : cnt_q + CW'(1);
            end
            HOLD: begin
                state_d = !lock_s_q ? WAIT_LOCK : (cnt_q == HOLD_LAST) ? RUN : HOLD;
                cnt_d = (cnt_q == HOLD_LAST) ? '0 : cnt_q + CW'(1);
            end
            default: state_d = lock_s_q ? RUN : WAIT_LOCK;
        endcase
        run_d = (state_d == RUN);
        div_d = (state_q == RUN && run_d) ? div_q + 4'd1 : 4'd0;
        lock_drops_d = (state_q == RUN && !lock_s_q && lock_drops_q != 8'hff) ? lock_drops_q + 8'd1 : lock_drops_q;
`ifdef GB_DOUBLE_SPEED_EN
        speed_d = (state_q == RUN && div_q == 4'd15) ? double_speed : speed_q;
`else
        speed_d = 1'b0;
`endif
        sys_reset_d = !run_d;
        ce_ppu_d = run_d && (div_d[1:0] == 2'd3);
        ce_m_d = run_d && (speed_q ? (div_d[2:0] == 3'd7) : (div_d == 4'd15));
        ce_cpu_d = ce_ppu_d || (run_d && speed_q && div_d[0]);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_LOCK;
            cnt_q <= '0;
            div_q <= '0;
            lock_drops_q <= '0;
            meta_q <= 1'b0;
            lock_s_q <= 1'b0;
            speed_q <= 1'b0;
            sys_reset_q <= 1'b1;
            ce_ppu_q <= 1'b0;
            ce_cpu_q <= 1'b0;
            ce_m_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            div_q <= div_d;
            lock_drops_q <= lock_drops_d;
            meta_q <= locked;
            lock_s_q <= meta_q;
            speed_q <= speed_d;
            sys_reset_q <= sys_reset_d;
            ce_ppu_q <= ce_ppu_d;
            ce_cpu_q <= ce_cpu_d;
            ce_m_q <= ce_m_d;
        end
    end
    assign sys_reset = sys_reset_q;
    assign ce_ppu = ce_ppu_q;
    assign ce_cpu = ce_cpu_q;
    assign ce_m = ce_m_q;
    assign lock_drops = lock_drops_q;
endmodule

// File: tb/tb_gb_clk_rst_gen.sv
// tb_gb_clk_rst_gen: directed bench for gb_clk_rst_gen with LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4
module tb_gb_clk_rst_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic locked = 1'b0;
`ifdef GB_DOUBLE_SPEED_EN
    logic double_speed = 1'b0;
`endif
    logic sys_reset, ce_ppu, ce_cpu, ce_m;
    logic [7:0] lock_drops;
    int n_cmp = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    gb_clk_rst_gen #(.LOCK_STABLE_CYCLES(8), .RESET_HOLD_CYCLES(4)) dut (
        .clk(clk),
        .reset(reset),
        .locked(locked),
`ifdef GB_DOUBLE_SPEED_EN
        .double_speed(double_speed),
`endif
        .sys_reset(sys_reset),
        .ce_ppu(ce_ppu),
        .ce_cpu(ce_cpu),
        .ce_m(ce_m),
        .lock_drops(lock_drops)
    );
    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic strobes_off(input string tag);
        check({tag, "_rst"}, int'(sys_reset), 1);
        check({tag, "_ce"}, int'({ce_ppu, ce_cpu, ce_m}), 0);
    endtask
    // counts edges (starting with the one that first samples locked) until sys_reset drops
    task automatic edges_to_release(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (sys_reset && n < 200);
    endtask
    task automatic cadence(input int ncyc, input bit ds, input int exp_p, input int exp_c, input int exp_m);
        int np = 0, nc = 0, nm = 0, errs = 0;
        bit spd;
        for (int c = 1; c <= ncyc; c++) begin
`ifdef GB_DOUBLE_SPEED_EN
            if (ds && c == 5) double_speed = 1'b1;
`endif
            spd = ds && c >= 17;
            np += int'(ce_ppu);
            nc += int'(ce_cpu);
            nm += int'(ce_m);
            if (ce_ppu != (c % 4 == 0)) errs++;
            if (ce_cpu != (spd ? (c % 2 == 0) : (c % 4 == 0))) errs++;
            if (ce_m != (spd ? (c % 8 == 0) : (c % 16 == 0))) errs++;
            if (sys_reset) errs++;
            step();
        end
        check("cad_ppu_cnt", np, exp_p);
        check("cad_cpu_cnt", nc, exp_c);
        check("cad_m_cnt", nm, exp_m);
        check("cad_pattern_errs", errs, 0);
    endtask
    initial begin
        int n;
        step(3);
        reset = 1'b0;
        strobes_off("reset_state");
        check("reset_drops", int'(lock_drops), 0);
        locked = 1'b1;
        edges_to_release(n);
        check("powerup_edges", n, 15);
        cadence(64, 1'b0, 16, 16, 4);
        for (int i = 0; i < 20; i++) begin
            locked = 1'b0;
            step(2);
            if (i == 0) check("drop_e2_rst", int'(sys_reset), 0);
            step();
            strobes_off("drop");
            locked = 1'b1;
            edges_to_release(n);
            check("relock_edges", n, 15);
        end
        check("drops_20", int'(lock_drops), 20);
        for (int i = 0; i < 300; i++) begin
            locked = 1'b0;
            step(3);
            locked = 1'b1;
            edges_to_release(n);
        end
        check("drops_sat", int'(lock_drops), 255);
        step(9);
        reset = 1'b1;
        step();
        strobes_off("ext_reset");
        check("ext_reset_div", int'(dut.div_q), 0);
        check("ext_reset_drops", int'(lock_drops), 0);
        reset = 1'b0;
        edges_to_release(n);
        check("ext_requal_edges", n, 15);
        cadence(16, 1'b0, 4, 4, 1);
        reset = 1'b1;
        locked = 1'b0;
        step(3);
        reset = 1'b0;
        locked = 1'b1;
        step(5);
        locked = 1'b0;
        step();
        locked = 1'b1;
        edges_to_release(n);
        check("unstable_edges", n, 15);
        check("unstable_drops", int'(lock_drops), 0);
`ifdef GB_DOUBLE_SPEED_EN
        cadence(64, 1'b1, 16, 28, 7);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gb_clk_rst_gen.md
# gb_clk_rst_gen

Clock-domain housekeeping stage directly downstream of the 16.875 MHz system PLL. Consumes the PLL output clock and its raw `locked` flag, and produces a clean synchronous system reset plus the Game Boy clock-enable strobes (PPU dot, CPU, machine cycle) used by every core block. Reset is held until lock has been stable for a programmable time, and is re-asserted on any lock loss.

## Interface
- `LOCK_STABLE_CYCLES`, default 1024: consecutive cycles synchronized lock must stay high before the reset hold phase starts (≥1).
- `RESET_HOLD_CYCLES`, default 16: cycles `sys_reset` stays high after lock qualification (≥1).
- `clk` input 1: PLL global output clock; the only clock.
- `reset` input 1: synchronous, active-high external reset.
- `locked` input 1: raw PLL lock, asynchronous to `clk`.
- `double_speed` input 1: CGB double-speed request; present only with `GB_DOUBLE_SPEED_EN`.
- `sys_reset` output 1: synchronous active-high reset for the core.
- `ce_ppu` output 1: one-cycle strobe, every 4 clocks.
- `ce_cpu` output 1: one-cycle CPU strobe, every 4 clocks, or every 2 in double speed.
- `ce_m` output 1: machine-cycle strobe, every 16 clocks, or every 8 in double speed.
- `lock_drops` output 8: saturating count of lock losses seen in RUN.

## Operation
- `locked` passes through a 2-flop synchronizer to give `lock_s`. Both flops reset to 0.
- FSM states:
  - **WAIT_LOCK**: stays while `lock_s`=0; goes to STABLE with the counter cleared.
  - **STABLE**: counts cycles with `lock_s`=1; after `LOCK_STABLE_CYCLES` counts, goes to HOLD with the counter cleared.
  - **HOLD**: counts `RESET_HOLD_CYCLES`, then goes to RUN.
  - **RUN**: terminal while locked.
- `lock_s`=0 in STABLE, HOLD or RUN sends the FSM to WAIT_LOCK on the next edge. A drop from RUN increments `lock_drops`, which saturates at 255.
- `sys_reset`=1 in every state except RUN. It is registered and is 0 only while the state is RUN.
- Divider `div` is 4 bits. It is held at 0 whenever the FSM is not in RUN and increments by 1 per cycle in RUN, wrapping 15→0.
- Strobe decodes are registered from `div` and are all 0 outside RUN:
  - `ce_ppu` = (`div[1:0]`==3).
  - `ce_m` = (`div`==15), or (`div[2:0]`==7) in double speed.
  - `ce_cpu` = `ce_ppu`, or (`div[0]`==1) in double speed.
- Whenever `ce_m`=1, `ce_ppu`=1 and `ce_cpu`=1 in the same cycle.
- External `reset`=1 forces: FSM to WAIT_LOCK, counters and `div` to 0, synchronizer flops to 0, `lock_drops` to 0. This applies mid-sequence and mid-RUN alike.
- If `reset` and a lock drop occur in the same cycle, `reset` wins and `lock_drops` ends at 0.

## Timing
- Reset values: `sys_reset`=1; `ce_ppu`, `ce_cpu`, `ce_m`=0; `lock_drops`=0.
- If `locked` is sampled high at edge E0 and stays high, `sys_reset` is low after edge E0 + 2 + `LOCK_STABLE_CYCLES` + `RESET_HOLD_CYCLES`.
- RUN cycles are numbered from 1, where cycle 1 is the first cycle with `sys_reset`=0.
- Normal speed:
  - `ce_ppu`/`ce_cpu` high in cycles 4, 8, 12, …
  - `ce_m` high in cycles 16, 32, …
- Double speed:
  - `ce_cpu` high in cycles 2, 4, 6, …
  - `ce_m` high in cycles 8, 16, …
- Lock loss: `locked` falling at edge E gives `sys_reset`=1 and all strobes 0 after edge E+3.
- A `locked` glitch shorter than 2 cycles may be missed. This is acceptable.

## Configuration
- `GB_DOUBLE_SPEED_EN` defined:
  - The `double_speed` port exists.
  - The internal speed flag samples `double_speed` only in cycles where `div`==15, so a speed change takes effect at a 16-cycle frame boundary and the PPU cadence is never disturbed.
  - The speed flag resets to 0.
- `GB_DOUBLE_SPEED_EN` undefined:
  - The port is absent.
  - The speed flag is the constant 0, and `ce_cpu` is identical to `ce_ppu`.

## Test plan
Benches use `LOCK_STABLE_CYCLES`=8 and `RESET_HOLD_CYCLES`=4.
- **Power-up:** `reset` high for 3 cycles, then low; `locked` rises at edge E0 → `sys_reset` low after exactly E0+14, and no strobe before RUN cycle 4.
- **Strobe cadence:** run 64 RUN cycles at normal speed → 16 `ce_ppu`, 16 `ce_cpu`, and 4 `ce_m` pulses, with `ce_m` at cycles 16/32/48/64 coincident with `ce_ppu`.
- **Unstable lock:** `locked` high 5 cycles, low 1 cycle, high again → no `sys_reset` release until 14 edges after the second rise; `lock_drops` stays 0.
- **Lock loss in RUN:** drop `locked` 20 times in RUN, each followed by relock → `sys_reset` high 3 edges after each drop, and `lock_drops`=20; repeat 300 drops → `lock_drops`=255.
- **External reset mid-RUN:** assert `reset` in RUN cycle 10 → next cycle `sys_reset`=1, `div`=0 and `lock_drops`=0; full qualification is repeated.
- **Speed switch (`GB_DOUBLE_SPEED_EN`):** raise `double_speed` in RUN cycle 5 → `ce_cpu` doubles starting cycle 18, `ce_m` next at cycles 24 and 32, and `ce_ppu` unchanged at every 4th cycle.
